addr_accumulator: RTL and testbench
===================================

ADDR_ACCUMULATOR -- requirements
Module: addr_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving log2 of the words per period.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 14, giving the signed sample width.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 32, giving the signed accumulator width.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 addr  in  WIDTH+2  byte address from the upstream address generator; word index = addr[WIDTH+1:2].
REQ-007 tvalid  in  1  addr and din are valid this cycle.
REQ-008 restart  in  1  pulse coinciding with the first sample (word 0) of a new period.
REQ-009 din  in  DATA_WIDTH  signed sample aligned with addr.
REQ-010 avg_on  in  1  accumulation enable.
REQ-011 n_avg  in  32  number of periods per frame.
REQ-012 wen  out  1  result write strobe to the downstream BRAM.
REQ-013 waddr  out  WIDTH+2  byte address of the result.
REQ-014 wdata  out  ACC_WIDTH  sign-extended accumulated sum.
REQ-015 ready  out  1  one-cycle pulse when a frame is complete.
REQ-016 n_frames  out  32  number of completed frames.

Function
REQ-017 States SHALL be IDLE, FIRST, ACCUM and LAST; transitions SHALL occur only on a cycle with restart=1 and tvalid=1.
REQ-018 IDLE->FIRST SHALL occur on restart with avg_on=1; n_avg is latched at that point, with 0 treated as 1.
REQ-019 FIRST SHALL store din into RAM at the word index, overwriting the old contents.
REQ-020 ACCUM SHALL store RAM[word] + din.
REQ-021 LAST SHALL drive wen=1, waddr=addr and wdata=RAM[word] + din (or din alone when latched n_avg=1), and SHALL also clear the RAM word to 0.
REQ-022 Transitions SHALL depend on the period counter p, which counts from 0 within the frame:
  - p=0: FIRST, or LAST if latched n_avg=1.
  - 0<p<n_avg-1: ACCUM.
  - p=n_avg-1: LAST.
REQ-023 On restart in LAST, the FSM SHALL go to FIRST if avg_on=1, else to IDLE.
REQ-024 On restart in FIRST or ACCUM, if avg_on=0 the FSM SHALL go to IDLE and discard the frame.
REQ-025 Pipeline latency SHALL be 2 cycles: a sample at cycle t produces its RAM write, and in LAST its wen, at t+2.
REQ-026 The RAM SHALL read at t; the sum SHALL be registered at t+1 and written at t+2.
REQ-027 Read-after-write to the same word within 2 cycles (periods of 1 or 2 words) SHALL be resolved by forwarding, with a result identical to an unpipelined accumulator.
REQ-028 Samples with tvalid=0 SHALL be ignored and the pipeline SHALL hold no bubble state.
REQ-029 ready SHALL pulse at t+2, where t is the restart ending a LAST period; n_frames SHALL increment in that same cycle and wrap modulo 2^32.
REQ-030 Sums SHALL wrap modulo 2^ACC_WIDTH unless ADDR_ACC_SATURATE_EN is defined.
REQ-031 In IDLE, wen SHALL be 0 and the RAM SHALL NOT be written.

Reset
REQ-032 On rst the block SHALL go to IDLE, set p=0, wen=0, waddr=0, wdata=0, ready=0 and n_frames=0, and flush the pipeline with no wen in the cycle after rst.
REQ-033 RAM contents SHALL NOT be cleared by rst; the next FIRST period overwrites them.
REQ-034 A rst during mid-frame SHALL abort the frame and produce no ready.

Configuration
REQ-035 With ADDR_ACC_SATURATE_EN defined, sums SHALL clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
REQ-036 Without ADDR_ACC_SATURATE_EN, sums SHALL wrap two's-complement.

Structure
REQ-037 Package addr_acc_pkg SHALL hold the state enum, the default WIDTH/DATA_WIDTH/ACC_WIDTH constants and the pipeline latency constant (2).
REQ-038 Sub-module addr_acc_ram SHALL be a simple dual-port RAM of 2^WIDTH x ACC_WIDTH with 1-cycle registered read and write-first-irrelevant semantics (forwarding handled in the parent).

Verification
REQ-039 With WIDTH=8, n_avg=4, avg_on=1, din=word index, and a 256-word period repeated 8 times: wen fires for 256 cycles at the end of periods 4 and 8 with wdata=4*index, ready pulses twice and n_frames=2.
REQ-040 With n_avg=1 and din=-5 constant: every period emits wdata=-5 (sign-extended) with 2-cycle latency, and ready follows each period.
REQ-041 With n_avg=3 and a 1-word period (restart every cycle) and din=1: wdata=3 on every third sample with no forwarding error.
REQ-042 With din=2^(DATA_WIDTH-1)-1, ACC_WIDTH=16 and n_avg=8: the result clamps to 32767 with ADDR_ACC_SATURATE_EN defined and wraps without it.
REQ-043 With rst asserted mid-ACCUM, then restarted with n_avg=2: no ready occurs before the reset, and the post-reset frame yields the exact 2-period sum unaffected by stale RAM.
REQ-044 With avg_on dropped during ACCUM: the FSM reaches IDLE at the next restart, there is no wen and no ready, and re-enabling starts a clean frame.

Source files
------------

// File: rtl/addr_acc_pkg.sv
// Shared types and defaults for the address-indexed period accumulator.
package addr_acc_pkg;

    localparam int unsigned DefWidth     = 8;
    localparam int unsigned DefDataWidth = 14;
    localparam int unsigned DefAccWidth  = 32;
    localparam int unsigned PipeLatency  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StFirst,
        StAccum,
        StLast
    } state_e;

    // Role of period p in a frame of n_avg periods (n_avg already forced >= 1).
    function automatic state_e period_state(input logic [31:0] p, input logic [31:0] n_avg);
        if (p == n_avg - 32'd1) begin
            return StLast;
        end
        if (p == 32'd0) begin
            return StFirst;
        end
        return StAccum;
    endfunction

endpackage

// File: rtl/addr_acc_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module addr_acc_ram #(
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [AddrWidth-1:0] raddr,
    output logic [DataWidth-1:0] rdata
);

    logic [DataWidth-1:0] mem [0:(1 << AddrWidth) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/addr_accumulator.sv
// Averages n_avg periods of address-indexed samples into RAM; emits sums in the last period.
// Define ADDR_ACC_SATURATE_EN to clamp sums instead of wrapping.
module addr_accumulator
    import addr_acc_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ACC_WIDTH  = DefAccWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH+1:0]      addr,
    input  logic                  tvalid,
    input  logic                  restart,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  avg_on,
    input  logic [31:0]           n_avg,
    output logic                  wen,
    output logic [WIDTH+1:0]      waddr,
    output logic [ACC_WIDTH-1:0]  wdata,
    output logic                  ready,
    output logic [31:0]           n_frames
);

    state_e      state_q, state_d;
    logic [31:0] p_q, p_d;
    logic [31:0] n_avg_q, n_avg_d;
    logic        start, frame_end;
    logic        op_valid, op_first, op_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            p_q     <= '0;
            n_avg_q <= 32'd1;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            n_avg_q <= n_avg_d;
        end
    end

    // The restart sample already belongs to the new period, so ops use the _d values.
    always_comb begin
        start     = restart && tvalid;
        state_d   = state_q;
        p_d       = p_q;
        n_avg_d   = n_avg_q;
        frame_end = 1'b0;
        if (start) begin
            unique case (state_q)
                StIdle: begin
                    if (avg_on) begin
                        n_avg_d = (n_avg == 32'd0) ? 32'd1 : n_avg;
                        p_d     = '0;
                        state_d = period_state(32'd0, n_avg_d);
                    end
                end
                StFirst, StAccum: begin
                    if (avg_on) begin
                        p_d     = p_q + 32'd1;
                        state_d = period_state(p_d, n_avg_q);
                    end else begin
                        p_d     = '0;
                        state_d = StIdle;
                    end
                end
                StLast: begin
                    frame_end = 1'b1;
                    p_d       = '0;
                    state_d   = avg_on ? period_state(32'd0, n_avg_q) : StIdle;
                end
                default: begin
                    p_d     = '0;
                    state_d = StIdle;
                end
            endcase
        end
        op_valid = tvalid && (state_d != StIdle);
        op_first = (p_d == 32'd0);
        op_last  = (state_d == StLast);
    end

    // Pipeline: s1 = RAM read returning, s2 = registered sum being written.
    logic                  s1_valid_q, s1_first_q, s1_last_q;
    logic [WIDTH+1:0]      s1_addr_q;
    logic [DATA_WIDTH-1:0] s1_din_q;
    logic                  s2_valid_q, s2_last_q;
    logic [WIDTH+1:0]      s2_addr_q;
    logic [ACC_WIDTH-1:0]  s2_sum_q;
    logic                  s3_valid_q;
    logic [WIDTH-1:0]      s3_word_q;
    logic [ACC_WIDTH-1:0]  s3_data_q;
    logic [PipeLatency-1:0] ready_pipe_q;
    logic [31:0]           n_frames_q;

    logic [WIDTH-1:0]      s1_word, s2_word;
    logic [ACC_WIDTH-1:0]  ram_rdata, ram_wdata;
    logic [ACC_WIDTH-1:0]  prev, base, din_ext, sum;

    assign s1_word   = s1_addr_q[WIDTH+1:2];
    assign s2_word   = s2_addr_q[WIDTH+1:2];
    assign ram_wdata = s2_last_q ? '0 : s2_sum_q;

    addr_acc_ram #(
        .AddrWidth (WIDTH),
        .DataWidth (ACC_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (s2_valid_q),
        .waddr (s2_word),
        .wdata (ram_wdata),
        .raddr (addr[WIDTH+1:2]),
        .rdata (ram_rdata)
    );

    // Writes from the two previous samples are not yet visible in ram_rdata.
    always_comb begin
        prev = ram_rdata;
        if (s2_valid_q && (s2_word == s1_word)) begin
            prev = ram_wdata;
        end else if (s3_valid_q && (s3_word_q == s1_word)) begin
            prev = s3_data_q;
        end
        base    = s1_first_q ? '0 : prev;
        din_ext = {{(ACC_WIDTH - DATA_WIDTH){s1_din_q[DATA_WIDTH-1]}}, s1_din_q};
`ifdef ADDR_ACC_SATURATE_EN
        begin
            logic [ACC_WIDTH:0] sum_wide;
            sum_wide = {base[ACC_WIDTH-1], base} + {din_ext[ACC_WIDTH-1], din_ext};
            if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
                sum = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
            end else begin
                sum = sum_wide[ACC_WIDTH-1:0];
            end
        end
`else
        sum = base + din_ext;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_addr_q    <= '0;
            s1_din_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_addr_q    <= '0;
            s2_sum_q     <= '0;
            s3_valid_q   <= 1'b0;
            s3_word_q    <= '0;
            s3_data_q    <= '0;
            ready_pipe_q <= '0;
            n_frames_q   <= '0;
        end else begin
            s1_valid_q <= op_valid;
            if (op_valid) begin
                s1_first_q <= op_first;
                s1_last_q  <= op_last;
                s1_addr_q  <= addr;
                s1_din_q   <= din;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_last_q <= s1_last_q;
                s2_addr_q <= s1_addr_q;
                s2_sum_q  <= sum;
            end
            s3_valid_q   <= s2_valid_q;
            s3_word_q    <= s2_word;
            s3_data_q    <= ram_wdata;
            ready_pipe_q <= {ready_pipe_q[PipeLatency-2:0], frame_end};
            if (ready_pipe_q[PipeLatency-2]) begin
                n_frames_q <= n_frames_q + 32'd1;
            end
        end
    end

    assign wen      = s2_valid_q && s2_last_q;
    assign waddr    = s2_addr_q;
    assign wdata    = s2_sum_q;
    assign ready    = ready_pipe_q[PipeLatency-1];
    assign n_frames = n_frames_q;

endmodule

// File: tb/tb_addr_accumulator.sv
// Randomized bench for addr_accumulator against a period-level reference model.
module tb_addr_accumulator;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DW     = 14;
    localparam int unsigned ACC    = 16;
    localparam int unsigned AW     = WIDTH + 2;
    localparam int unsigned NWORDS = 1 << WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tvalid = 1'b0;
    logic          restart = 1'b0;
    logic          avg_on = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic [31:0]   n_avg = '0;
    logic          wen, ready;
    logic [AW-1:0] waddr;
    logic [ACC-1:0] wdata;
    logic [31:0]   n_frames;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic           wen;
        logic [AW-1:0]  waddr;
        logic [ACC-1:0] wdata;
        logic           ready;
    } exp_t;

    exp_t        exp_q[$];
    bit          m_active;
    longint      m_n, m_p;
    longint      m_acc [NWORDS];
    logic [31:0] m_frames;

    always #5 clk = ~clk;

    addr_accumulator #(
        .WIDTH      (WIDTH),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (ACC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .tvalid   (tvalid),
        .restart  (restart),
        .din      (din),
        .avg_on   (avg_on),
        .n_avg    (n_avg),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .ready    (ready),
        .n_frames (n_frames)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clamp or wrap to the accumulator range after every addition.
    function automatic longint fix(input longint v);
        longint m;
        m = longint'(1) <<< ACC;
`ifdef ADDR_ACC_SATURATE_EN
        if (v > m / 2 - 1) return m / 2 - 1;
        if (v < -(m / 2)) return -(m / 2);
        return v;
`else
        v = v & (m - 1);
        if (v >= m / 2) v = v - m;
        return v;
`endif
    endfunction

    task automatic model_sample(input bit rs, input bit tv, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, output exp_t e);
        int          w;
        logic [63:0] t;
        e = '0;
        if (tv) begin
            if (rs) begin
                if (!m_active) begin
                    if (avg_on) begin
                        m_active = 1'b1;
                        m_n      = (n_avg == 32'd0) ? 1 : longint'(n_avg);
                        m_p      = 0;
                    end
                end else if (m_p == m_n - 1) begin
                    e.ready = 1'b1;
                    if (avg_on) m_p = 0;
                    else m_active = 1'b0;
                end else if (avg_on) begin
                    m_p++;
                end else begin
                    m_active = 1'b0;
                end
            end
            if (m_active) begin
                w = int'(a[AW-1:2]);
                m_acc[w] = fix(((m_p == 0) ? 0 : m_acc[w]) + longint'($signed(d)));
                if (m_p == m_n - 1) begin
                    t       = m_acc[w];
                    e.wen   = 1'b1;
                    e.waddr = a;
                    e.wdata = t[ACC-1:0];
                end
            end
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        if (e.ready) m_frames = m_frames + 32'd1;
        chk("wen", wen, e.wen);
        if (e.wen) begin
            chk("waddr", waddr, e.waddr);
            chk("wdata", wdata, e.wdata);
        end
        chk("ready", ready, e.ready);
        chk("n_frames", n_frames, m_frames);
    endtask

    // Called at a falling edge; checks, drives one sample, advances to next falling edge.
    task automatic cycle(input bit rs, input bit tv, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        exp_t e;
        check_outputs();
        restart = rs;
        tvalid  = tv;
        addr    = a;
        din     = d;
        model_sample(rs, tv, a, d, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        tvalid = 1'b0;
        restart = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_wen", wen, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_ready", ready, 0);
        chk("rst_n_frames", n_frames, 0);
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        m_active = 1'b0;
        m_p      = 0;
        m_frames = '0;
    endtask

    // mode 0: din = word index, 1: din = cval, 2: random din.
    task automatic period(input int nw, input int mode, input logic [DW-1:0] cval,
                          input bit gaps);
        logic [WIDTH-1:0] wi;
        logic [AW-1:0]    a;
        logic [DW-1:0]    d;
        for (int w = 0; w < nw; w++) begin
            if (gaps && $urandom_range(3) == 0) begin
                cycle(1'($urandom_range(1)), 1'b0, AW'($urandom), DW'($urandom));
            end
            wi = WIDTH'(w);
            a  = {wi, 2'($urandom_range(3))};
            d  = (mode == 0) ? DW'(w) : (mode == 1) ? cval : DW'($urandom);
            cycle(w == 0, 1'b1, a, d);
        end
    endtask

    task automatic end_frame();
        avg_on = 1'b0;
        cycle(1'b1, 1'b1, '0, '0);
        repeat (4) cycle(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [ACC-1:0] sat_exp;
        @(negedge clk);
        do_reset();

        // Full 256-word periods, two frames of four.
        avg_on = 1'b1;
        n_avg  = 32'd4;
        repeat (8) period(NWORDS, 0, '0, 1'b0);
        end_frame();
        chk("frames_after_avg4", n_frames, 2);

        // Single-period frames with a constant negative sample.
        do_reset();
        avg_on = 1'b1;
        n_avg  = 32'd1;
        repeat (4) period(6, 1, DW'(-5), 1'b1);
        end_frame();

        // One-word and two-word periods stress the forwarding paths.
        avg_on = 1'b1;
        n_avg  = 32'd3;
        repeat (9) period(1, 1, DW'(1), 1'b0);
        end_frame();
        avg_on = 1'b1;
        n_avg  = 32'd2;
        repeat (6) period(2, 2, '0, 1'b1);
        end_frame();

        // Large positive samples overflow a 16-bit accumulator.
        avg_on = 1'b1;
        n_avg  = 32'd8;
        repeat (8) period(4, 1, DW'(8191), 1'b0);
        end_frame();
`ifdef ADDR_ACC_SATURATE_EN
        sat_exp = 16'h7fff;
`else
        sat_exp = 16'hfff8;
`endif
        chk("overflow_wdata", wdata, sat_exp);

        // Random frame lengths, period sizes and gaps; n_avg=0 acts as 1.
        for (int k = 0; k < 6; k++) begin
            int nw;
            avg_on = 1'b1;
            n_avg  = 32'($urandom_range(4));
            nw     = $urandom_range(1, 5);
            repeat (2 * int'(n_avg) + 2) period(nw, 2, '0, 1'b1);
            end_frame();
        end

        // Reset in the middle of an accumulating period, then a clean 2-period frame.
        avg_on = 1'b1;
        n_avg  = 32'd4;
        repeat (2) period(8, 2, '0, 1'b0);
        cycle(1'b1, 1'b1, '0, DW'(123));
        do_reset();
        avg_on = 1'b1;
        n_avg  = 32'd2;
        repeat (2) period(8, 2, '0, 1'b0);
        end_frame();

        // Dropping avg_on mid-frame discards it; re-enable starts fresh.
        avg_on = 1'b1;
        n_avg  = 32'd3;
        repeat (2) period(5, 2, '0, 1'b0);
        avg_on = 1'b0;
        repeat (2) period(5, 2, '0, 1'b1);
        avg_on = 1'b1;
        n_avg  = 32'd2;
        repeat (2) period(5, 2, '0, 1'b1);
        end_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
